// File: rtl/onehot_decoder_display_pkg.sv
// Shared types and constants for the one-hot decoder display.
// Digit index, anode patterns, blank segment code and FSM states.
package onehot_decoder_display_pkg;

    localparam int IDX_W = 2;

    typedef logic [IDX_W-1:0] idx_t;

    localparam logic [7:0] BLANK_SEG = 8'hFF;

    typedef enum logic {
        EMPTY = 1'b0,
        SHOW  = 1'b1
    } state_t;

    // Active-low select: exactly one anode low per digit index.
    function automatic logic [3:0] anode_for(idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/segment_decoder.sv
// Three-bit digit to active-low seven-segment pattern.
// Bit order is {dp,g,f,e,d,c,b,a}; decimal point stays dark.
module segment_decoder
    import onehot_decoder_display_pkg::*;
(
    input  logic [2:0] digit,
    output logic [7:0] seg
);

    always_comb begin
        seg = BLANK_SEG;
        unique case (digit)
            3'd0: seg = 8'hC0;
            3'd1: seg = 8'hF9;
            3'd2: seg = 8'hA4;
            3'd3: seg = 8'hB0;
            3'd4: seg = 8'h99;
            3'd5: seg = 8'h92;
            3'd6: seg = 8'h82;
            3'd7: seg = 8'hF8;
        endcase
    end

endmodule

// File: rtl/onehot_decoder_display.sv
// One-hot decoder with a four-digit multiplexed status display.
// Shows current code, previous code and a wrapping accept count.
module onehot_decoder_display
    import onehot_decoder_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] code,
    input  logic       code_valid,
    output logic       code_ready,
    input  logic       enable,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic [7:0] segments,
    output logic [3:0] anodes
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    state_t        state;
    logic [2:0]    cur_code;
    logic [2:0]    prev_code;
    logic [2:0]    accept_cnt;
    logic          prev_valid;
    logic [CW-1:0] scan_cnt;
    idx_t          idx;

    logic          accept;
    logic          wrap;
    logic          blank;
    logic [2:0]    digit;
    logic [7:0]    dec_seg;

    assign code_ready = enable;
    assign accept     = code_valid & enable;
    assign wrap       = (scan_cnt == CNT_MAX);
    assign dout_valid = (state == SHOW);

    always_comb begin
        digit = 3'd0;
        blank = 1'b1;
        unique case (idx)
            2'd0: begin
                digit = cur_code;
                blank = (state == EMPTY);
            end
            2'd1: begin
                digit = prev_code;
                blank = !prev_valid;
            end
            2'd2: begin
                digit = accept_cnt;
                blank = (state == EMPTY);
            end
            2'd3: begin
                digit = 3'd0;
                blank = 1'b1;
            end
        endcase
    end

    segment_decoder u_seg (
        .digit (digit),
        .seg   (dec_seg)
    );

    // Display outputs are registered from the current index so that
    // anode and segment changes land on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            dout       <= 8'h00;
            cur_code   <= 3'd0;
            prev_code  <= 3'd0;
            prev_valid <= 1'b0;
            accept_cnt <= 3'd0;
            scan_cnt   <= '0;
            idx        <= '0;
            anodes     <= 4'b1110;
            segments   <= BLANK_SEG;
        end else if (enable) begin
            scan_cnt <= wrap ? '0 : scan_cnt + 1'b1;
            if (wrap) begin
                idx <= idx + 1'b1;
            end
            anodes   <= anode_for(idx);
            segments <= blank ? BLANK_SEG : dec_seg;
            if (accept) begin
                dout       <= 8'd1 << code;
                cur_code   <= code;
                prev_code  <= cur_code;
                accept_cnt <= accept_cnt + 3'd1;
                state      <= SHOW;
                if (state == SHOW) begin
                    prev_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_onehot_decoder_display.sv
// Directed self-checking bench for onehot_decoder_display.
// Runs with REFRESH_DIV = 4 so each digit holds four cycles.
module tb_onehot_decoder_display;

    logic       clk;
    logic       rst;
    logic [2:0] code;
    logic       code_valid;
    logic       code_ready;
    logic       enable;
    logic [7:0] dout;
    logic       dout_valid;
    logic [7:0] segments;
    logic [3:0] anodes;

    int n_chk;
    int n_fail;

    logic [7:0] seg_tab [8];
    logic [3:0] an_tab  [4];

    onehot_decoder_display #(
        .REFRESH_DIV (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .enable     (enable),
        .dout       (dout),
        .dout_valid (dout_valid),
        .segments   (segments),
        .anodes     (anodes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        code_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Wait for the first cycle a digit becomes lit.
    task automatic wait_first(input logic [3:0] pat, input string tag);
        logic [3:0] prev;
        bit found;
        prev  = anodes;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (anodes === pat && prev !== pat) found = 1'b1;
            else prev = anodes;
        end
        chk({tag, "_reach"}, 32'(found), 32'd1);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0,
                    8'h99, 8'h92, 8'h82, 8'hF8};
        an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        rst        = 1'b1;
        code       = 3'd0;
        code_valid = 1'b0;
        enable     = 1'b1;
        #1;
        chk("rst_dout", 32'(dout), 32'h00);
        chk("rst_dvalid", 32'(dout_valid), 32'd0);
        chk("rst_anodes", 32'(anodes), 32'(4'b1110));
        chk("rst_seg", 32'(segments), 32'hFF);
        chk("rst_ready", 32'(code_ready), 32'd1);

        tick();
        rst = 1'b0;

        // Idle scan: all blank, anodes rotate every four cycles.
        for (int n = 1; n <= 40; n++) begin
            tick();
            chk("idle_anodes", 32'(anodes), 32'(an_tab[((n - 1) / 4) % 4]));
            chk("idle_seg", 32'(segments), 32'hFF);
            chk("idle_dout", 32'(dout), 32'h00);
            chk("idle_dvalid", 32'(dout_valid), 32'd0);
        end

        // First accept: code 5.
        code = 3'd5;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        chk("a5_dout", 32'(dout), 32'h20);
        chk("a5_dvalid", 32'(dout_valid), 32'd1);
        wait_first(4'b1110, "a5_d0");
        chk("a5_d0_seg", 32'(segments), 32'(seg_tab[5]));
        wait_first(4'b1101, "a5_d1");
        chk("a5_d1_seg", 32'(segments), 32'hFF);
        wait_first(4'b1011, "a5_d2");
        chk("a5_d2_seg", 32'(segments), 32'(seg_tab[1]));
        wait_first(4'b0111, "a5_d3");
        chk("a5_d3_seg", 32'(segments), 32'hFF);

        // Back-to-back accepts 3 then 6.
        do_reset();
        code = 3'd3;
        code_valid = 1'b1;
        tick();
        chk("a3_dout", 32'(dout), 32'h08);
        code = 3'd6;
        tick();
        code_valid = 1'b0;
        chk("a6_dout", 32'(dout), 32'h40);
        wait_first(4'b1110, "a36_d0");
        chk("a36_d0_seg", 32'(segments), 32'(seg_tab[6]));
        wait_first(4'b1101, "a36_d1");
        chk("a36_d1_seg", 32'(segments), 32'(seg_tab[3]));
        wait_first(4'b1011, "a36_d2");
        chk("a36_d2_seg", 32'(segments), 32'(seg_tab[2]));
        wait_first(4'b0111, "a36_d3");
        chk("a36_d3_seg", 32'(segments), 32'hFF);

        // Nine accepts of code 0: count wraps to 1.
        do_reset();
        code = 3'd0;
        code_valid = 1'b1;
        repeat (9) tick();
        code_valid = 1'b0;
        chk("a0x9_dout", 32'(dout), 32'h01);
        wait_first(4'b1110, "a0x9_d0");
        chk("a0x9_d0_seg", 32'(segments), 32'(seg_tab[0]));
        wait_first(4'b1101, "a0x9_d1");
        chk("a0x9_d1_seg", 32'(segments), 32'(seg_tab[0]));

        // Freeze on the first cycle of digit 1.
        enable = 1'b0;
        code = 3'd7;
        code_valid = 1'b1;
        #1;
        chk("frz_ready", 32'(code_ready), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("frz_dout", 32'(dout), 32'h01);
            chk("frz_anodes", 32'(anodes), 32'(4'b1101));
            chk("frz_seg", 32'(segments), 32'(seg_tab[0]));
        end
        enable = 1'b1;
        code_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("res_anodes", 32'(anodes), 32'(4'b1101));
        end
        tick();
        chk("res_next_anodes", 32'(anodes), 32'(4'b1011));
        chk("res_cnt_seg", 32'(segments), 32'(seg_tab[1]));
        chk("res_dout", 32'(dout), 32'h01);

        // Asynchronous reset mid-digit after accepting 4.
        do_reset();
        code = 3'd4;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        chk("a4_dout", 32'(dout), 32'h10);
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_dout", 32'(dout), 32'h00);
        chk("arst_dvalid", 32'(dout_valid), 32'd0);
        chk("arst_anodes", 32'(anodes), 32'(4'b1110));
        chk("arst_seg", 32'(segments), 32'hFF);
        code = 3'd2;
        code_valid = 1'b1;
        tick();
        rst = 1'b0;
        code_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_dout", 32'(dout), 32'h00);
            chk("post_dvalid", 32'(dout_valid), 32'd0);
        end
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        chk("post_a2_dout", 32'(dout), 32'h04);
        wait_first(4'b1101, "post_d1");
        chk("post_d1_seg", 32'(segments), 32'hFF);
        wait_first(4'b1011, "post_d2");
        chk("post_d2_seg", 32'(segments), 32'(seg_tab[1]));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/onehot_decoder_display.md
ONEHOT_DECODER_DISPLAY -- requirements
Module: onehot_decoder_display

Interface
REQ-001 Parameter: REFRESH_DIV, default 100000, clk cycles each display digit stays lit (legal range 2..2^20).
REQ-002 Port: clk  input  1  single system clock, all state on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: code  input  3  binary code to decode (0..7).
REQ-005 Port: code_valid  input  1  code qualifier, one-cycle strobe or level.
REQ-006 Port: code_ready  output  1  block accepts code this cycle.
REQ-007 Port: enable  input  1  0 = freeze decode and display scan.
REQ-008 Port: dout  output  8  registered one-hot decode of last accepted code.
REQ-009 Port: dout_valid  output  1  high once any code has been accepted since reset.
REQ-010 Port: segments  output  8  active-low segment pattern for the currently lit digit.
REQ-011 Port: anodes  output  4  active-low digit select, exactly one bit low when scanning.

Function
REQ-012 code_ready SHALL equal enable (combinational); accept = code_valid & code_ready.
REQ-013 On accept, dout SHALL become (1 << code) on the next rising edge (latency 1 cycle); otherwise dout holds.
REQ-014 Accept SHALL also shift last code into prev_code, load code into cur_code, increment 3-bit accept_cnt (wraps 7 -> 0).
REQ-015 Repeated identical codes SHALL still count as accepts (counter increments, dout unchanged).
REQ-016 FSM states: EMPTY (no code since reset) and SHOW; EMPTY -> SHOW on first accept; SHOW has no exit except reset.
REQ-017 In EMPTY: dout = 8'h00, dout_valid = 0, prev_code display blank; in SHOW dout_valid = 1.
REQ-018 Until the second accept, the prev_code digit SHALL be blank (prev_valid flag).
REQ-019 Scan counter SHALL count 0..REFRESH_DIV-1 while enable = 1 and, on wrap, advance digit index 0->1->2->3->0.
REQ-020 enable = 0 SHALL hold scan counter, digit index, and all registers; anodes/segments keep last value.
REQ-021 Digit map: idx0 anodes 4'b1110 = cur_code; idx1 4'b1101 = prev_code; idx2 4'b1011 = accept_cnt; idx3 4'b0111 = blank.
REQ-022 Digit contents SHALL be converted by segment_decoder; blank digit SHALL drive segments = 8'hFF.
REQ-023 In EMPTY all four digits SHALL be blank (segments 8'hFF) while anodes still scan.
REQ-024 segments and anodes SHALL be registered (one cycle after digit index/content change); no glitch between digits.
REQ-025 Accept on the same cycle as a scan wrap SHALL apply both; new digit shows new content one cycle later.

Reset
REQ-026 rst high SHALL immediately force: dout = 8'h00, dout_valid = 0, FSM = EMPTY, cur/prev_code = 0, prev_valid = 0, accept_cnt = 0, scan counter = 0, digit index = 0, anodes = 4'b1110, segments = 8'hFF.
REQ-027 Reset asserted mid-scan or mid-accept SHALL discard the in-flight accept; first edge after release behaves as from EMPTY.

Structure
REQ-028 Shared package: digit index width, anode patterns per index, BLANK_SEG = 8'hFF, FSM state encoding.
REQ-029 One sub-module: the existing segment_decoder (3-bit digit in, 8-bit segments out), instantiated once on the muxed digit.
REQ-030 Counter width SHALL be $clog2(REFRESH_DIV); no other arithmetic beyond 3-bit wrap increment.

Verification (REFRESH_DIV = 4)
REQ-031 Reset then idle 40 cycles -> dout 8'h00, dout_valid 0, segments 8'hFF always, anodes cycle 1110,1101,1011,0111 each held 4 cycles.
REQ-032 Accept code 5 -> next cycle dout 8'h20, dout_valid 1; idx0 shows 5, idx1 blank, idx2 shows 1.
REQ-033 Accept 3 then 6 -> dout 8'h40; idx0 = 6, idx1 = 3, idx2 = 2.
REQ-034 Nine accepts of code 0 -> dout 8'h01, accept_cnt = 1 (wrap), idx1 = 0.
REQ-035 enable = 0 with code_valid = 1, code 7 for 10 cycles -> code_ready 0, dout/anodes/segments frozen; re-enable resumes same digit and count.
REQ-036 Assert rst asynchronously mid-digit after accept of 4 -> outputs at reset values before next clk edge; dout_valid 0.
